// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared sizing helpers and defaults for the BRAM-backed FIFO family.
//   fifo_depth(aw)       : number of RAM entries for an aw-bit address
//   fifo_count_width(aw) : bits needed to hold an occupancy of 0..depth
//   AFULL_MARGIN         : default distance from full at which almost_full rises
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int AFULL_MARGIN = 2;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit beyond the address so that "full" (count == depth) is
    // representable and distinct from "empty".
    function automatic int fifo_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bram.sv
// -----------------------------------------------------------------------------
// bram
// Simple dual-port RAM: one write port, one read port with a registered read
// address. Read data is mem[raddr latched at the last edge]. A write and an
// address latch to the same location on the same edge return the new word
// (write-first), because the read is taken from the array after the edge.
//
// Ports:
//   clk   in               : rising-edge clock
//   we    in               : write enable
//   waddr in  ADDR_WIDTH   : write address
//   din   in  DATA_WIDTH   : write data
//   raddr in  ADDR_WIDTH   : read address, latched every edge
//   dout  out DATA_WIDTH   : mem[latched raddr]
// -----------------------------------------------------------------------------
module bram
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] raddr_q;

    // NOTE: the array and its address register carry no reset; a reset would
    // stop the array mapping onto block RAM, and the FIFO never exposes
    // unwritten entries because out_valid follows the occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= din;
        end
        raddr_q <= raddr;
    end

    assign dout = mem_q[raddr_q];

endmodule

// File: rtl/bram_fifo.sv
// -----------------------------------------------------------------------------
// bram_fifo
// First-word-fall-through FIFO around the two-port bram. The read address fed
// to the RAM is the value rd_ptr will hold after the current edge, so the RAM's
// registered read always lands on the head entry and out_data needs no bypass.
//
// Optional feature: define BRAM_FIFO_HWM_EN to add the max_count high-water
// mark port (cleared only by rst, not by flush).
//
// Ports:
//   clk          in                : rising-edge clock
//   rst          in                : asynchronous active-high reset
//   flush        in                : synchronous empty; discards same-cycle push/pop
//   in_valid     in                : producer offers in_data
//   in_ready     out               : FIFO not full
//   in_data      in  DATA_WIDTH    : word to write
//   out_valid    out               : FIFO not empty, out_data is the head
//   out_ready    in                : consumer takes the head
//   out_data     out DATA_WIDTH    : head word
//   count        out ADDR_WIDTH+1  : occupancy 0..DEPTH
//   almost_full  out               : count >= AFULL_THRESH
//   max_count    out ADDR_WIDTH+1  : high-water mark (BRAM_FIFO_HWM_EN only)
// -----------------------------------------------------------------------------
module bram_fifo
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRESH = fifo_depth(ADDR_WIDTH) - AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full
`ifdef BRAM_FIFO_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]   max_count
`endif
);

    localparam int CW = fifo_count_width(ADDR_WIDTH);
    localparam logic [CW-1:0]         FULL_COUNT = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  push, pop;

    // Full/empty come from the count alone; pointer equality is ambiguous.
    assign in_ready    = (count_q != FULL_COUNT);
    assign out_valid   = (count_q != '0);
    assign almost_full = (int'(count_q) >= AFULL_THRESH);
    assign count       = count_q;

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef BRAM_FIFO_HWM_EN
    logic [CW-1:0] max_count_q;

    // Flush drives count_d to zero, which never exceeds the mark, so only
    // rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_count_q <= '0;
        end else if (count_d > max_count_q) begin
            max_count_q <= count_d;
        end
    end

    assign max_count = max_count_q;
`endif

    // The RAM is handed the post-edge read pointer (0 on flush, rd_ptr+1 on a
    // pop, else rd_ptr) so that after its registered read dout is the head.
    bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .din   (in_data),
        .raddr (rd_ptr_d),
        .dout  (out_data)
    );

endmodule

// File: tb/tb_bram_fifo.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo
// Scoreboard bench for bram_fifo (ADDR_WIDTH=3, DATA_WIDTH=32). A queue-based
// reference model predicts occupancy, flags and head word per cycle and the
// word expected for every pop; a monitor on the falling edge compares.
// -----------------------------------------------------------------------------
module tb_bram_fifo;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          almost_full;
`ifdef BRAM_FIFO_HWM_EN
    logic [AW:0]   max_count;
`endif

    always #5 clk = ~clk;

    bram_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
`ifdef BRAM_FIFO_HWM_EN
        ,
        .max_count   (max_count)
`endif
    );

    typedef struct {
        int            cnt;
        bit            in_rdy;
        bit            out_vld;
        bit            afull;
        logic [DW-1:0] head;
        int            maxc;
    } status_t;

    status_t       status_q[$];   // expected flags/head, one entry per cycle
    logic [DW-1:0] exp_pop_q[$];  // expected word for each accepted pop
    logic [DW-1:0] model_q[$];    // reference FIFO contents, head at index 0
    int            model_max;
    int            n_checks;
    int            n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs just after the rising edge, record what the
    // DUT must show during this cycle, then advance the model across the next edge.
    task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy,
                         input bit fl, input bit rs, output bit pushed);
        status_t s;
        int      sz;
        @(posedge clk);
        #1;
        rst       = rs;
        in_valid  = rs ? 1'b0 : iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        pushed    = 1'b0;
        if (rs) begin
            model_q.delete();
            model_max = 0;
        end
        sz        = model_q.size();
        s.cnt     = sz;
        s.in_rdy  = (sz < DEPTH);
        s.out_vld = (sz > 0);
        s.afull   = (sz >= AFULL);
        s.head    = (sz > 0) ? model_q[0] : '0;
        s.maxc    = model_max;
        status_q.push_back(s);
        if (!rs) begin
            if (fl) begin
                model_q.delete();
            end else begin
                if (ordy && sz > 0) exp_pop_q.push_back(model_q.pop_front());
                if (iv && sz < DEPTH) begin
                    model_q.push_back(d);
                    pushed = 1'b1;
                end
            end
        end
        if (model_q.size() > model_max) model_max = model_q.size();
    endtask

    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        bit unused;
        cycle(iv, d, ordy, fl, 1'b0, unused);
    endtask

    task automatic do_reset();
        bit unused;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, unused);
    endtask

    // Monitor: compare the DUT against the predicted state and pops.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                check("count",       count,       s.cnt);
                check("in_ready",    in_ready,    s.in_rdy);
                check("out_valid",   out_valid,   s.out_vld);
                check("almost_full", almost_full, s.afull);
                if (s.out_vld) check("head_data", out_data, s.head);
`ifdef BRAM_FIFO_HWM_EN
                check("max_count",   max_count,   s.maxc);
`endif
            end
            if (out_valid && out_ready && !flush && !rst) begin
                if (exp_pop_q.size() == 0) check("unexpected_pop", 1, 0);
                else check("pop_data", out_data, exp_pop_q.pop_front());
            end
        end
    end

    initial begin
        bit            acc;
        logic [DW-1:0] word;
        int            p_in;
        int            p_out;

        n_checks  = 0;
        n_pass    = 0;
        model_max = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        do_reset();
        do_reset();

        // Single word falls through one cycle after the push.
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill to full, then offer a ninth word that must be refused.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b0, 1'b0);

        // Full with both sides active: producer holds each word until taken.
        word = DW'(DEPTH);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, word, 1'b1, 1'b0, 1'b0, acc);
            if (acc) word = word + 1;
        end

        // Drain to 3, then simultaneous push/pop for 10 cycles.
        while (model_q.size() > 3) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h100 + i), 1'b1, 1'b0);

        // Count 5, flush with a push (and pop) offered: both are discarded.
        while (model_q.size() < 5) step(1'b1, DW'(32'h200 + model_q.size()), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // High-water mark: fill to 6, drain, flush, then reset clears it.
        do_reset();
        while (model_q.size() < 6) step(1'b1, DW'(32'h300 + model_q.size()), 1'b0, 1'b0);
        while (model_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic with shifting producer/consumer bias, rare flush/reset.
        p_in  = 50;
        p_out = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p_in  = $urandom_range(10, 95);
                p_out = $urandom_range(10, 95);
            end
            cycle($urandom_range(0, 99) < p_in, $urandom, $urandom_range(0, 99) < p_out,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, acc);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("status_left", status_q.size(), 0);
        check("pops_left",   exp_pop_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_fifo.md
# bram_fifo

First-word-fall-through FIFO wrapped around the team's two-port `bram` storage with a valid/ready handshake on both sides. It owns the read/write pointers and the occupancy count, and it drives `raddr`/`waddr`/`we` so that the head entry is always presented on `out_data` despite the RAM's registered read address. It sits between a producer stage, such as a fetch or DMA engine, and the consumer that reads the buffered words.

## Interface
- `ADDR_WIDTH`, 3: RAM address bits; DEPTH = 2^ADDR_WIDTH entries.
- `DATA_WIDTH`, 32: word width.
- `AFULL_THRESH`, DEPTH-2: `almost_full` asserts when count >= this value.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous empty request.
- `in_valid` in 1: producer has a word.
- `in_ready` out 1: FIFO accepts a word (= !full).
- `in_data` in DATA_WIDTH: write word.
- `out_valid` out 1: head word valid (= count != 0).
- `out_ready` in 1: consumer takes the head.
- `out_data` out DATA_WIDTH: head word; don't-care when `out_valid`=0.
- `count` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `almost_full` out 1: count >= AFULL_THRESH.
- `max_count` out ADDR_WIDTH+1: high-water mark. Present only with `BRAM_FIFO_HWM_EN`.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Registers:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits and wrap modulo DEPTH with no extra logic.
  - `count` is ADDR_WIDTH+1 bits.
- Full is count == DEPTH; empty is count == 0. Pointer equality is not used.
- RAM drive:
  - waddr = wr_ptr; din = in_data; we = push.
  - raddr = flush ? 0 : (pop ? rd_ptr+1 : rd_ptr), computed combinationally.
  - The RAM latches raddr each edge, so dout always equals mem[rd_ptr]; out_data = dout.
- Update on each edge:
  - flush has priority: wr_ptr, rd_ptr and count go to 0; push and pop that cycle are discarded.
  - Otherwise wr_ptr += push, rd_ptr += pop, count += push − pop.
  - Simultaneous push and pop leaves count unchanged.
- Write/read collision:
  - When a word is written to the address rd_ptr will hold after the edge, dout shows the new word in the next cycle.
  - The RAM is write-first for that case.
- Boundaries:
  - Full: in_ready=0, so a push is impossible even with pop in the same cycle; there is no pass-through.
  - Empty: out_valid=0, so no pop; no bypass of the RAM.
  - AFULL_THRESH > DEPTH makes almost_full never assert; this is legal.

## Timing
- Reset values (asynchronous): wr_ptr=0, rd_ptr=0, count=0, in_ready=1, out_valid=0, almost_full=0 (unless AFULL_THRESH=0), max_count=0.
- RAM contents are not reset.
- Write-to-read latency is 1 cycle: a word pushed at edge k gives out_valid=1 and out_data=that word in cycle k+1.
- Pop advance: a pop at edge k presents the next entry in cycle k+1 with no bubble.
- Sustained push and pop runs at 1 word per cycle.
- Flush at edge k gives out_valid=0, count=0 and in_ready=1 in cycle k+1.
- Reset mid-operation empties the FIFO immediately. Stale RAM words are never exposed, because out_valid tracks count.

## Configuration
- `BRAM_FIFO_HWM_EN` defined:
  - Port `max_count` exists.
  - The register updates to next_count whenever next_count > max_count.
  - It is cleared only by `rst`; flush does not clear it.
- Macro undefined: the port and the register are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - the DEPTH/count-width helper functions;
  - the default AFULL margin constant (2).
- One sub-module: `bram`, instantiated as storage with ADDR_WIDTH and DATA_WIDTH passed through.
- Pointer, count, flush and high-water logic stay in `bram_fifo`.

## Test plan
- Reset, then push 0xA1 with out_ready=0 → cycle after: out_valid=1, out_data=0xA1, count=1.
- ADDR_WIDTH=3, push 8 words 0..7 with no pops → in_ready=0 and count=8; almost_full rises at count=6; a 9th in_valid is not accepted.
- With the FIFO full, hold in_valid and out_ready high for 16 cycles → outputs 0..7 then subsequent words in order, wrap-around clean, one pop per cycle while nonempty.
- Hold count=3, assert push and pop together for 10 cycles → count stays 3, ordering preserved.
- Count=5, assert flush with in_valid=1 → next cycle count=0, out_valid=0, pushed word dropped.
- `BRAM_FIFO_HWM_EN`: fill to 6, drain to 0, flush → max_count=6; after `rst`, max_count=0.
